// File: rtl/ar_pkg.sv
// AR request type and default field widths shared by the arbiter and its users.
// Field order inside ar_req_t is MSB->LSB: id, addr, len, size, burst, qos.
package ar_pkg;

    localparam int AR_ID_W    = 4;
    localparam int AR_ADDR_W  = 32;
    localparam int AR_LEN_W   = 8;
    localparam int AR_SIZE_W  = 3;
    localparam int AR_BURST_W = 2;
    localparam int AR_QOS_W   = 4;

    typedef struct packed {
        logic [AR_ID_W-1:0]    id;
        logic [AR_ADDR_W-1:0]  addr;
        logic [AR_LEN_W-1:0]   len;
        logic [AR_SIZE_W-1:0]  size;
        logic [AR_BURST_W-1:0] burst;
        logic [AR_QOS_W-1:0]   qos;
    } ar_req_t;

    localparam int AR_W_DEF = $bits(ar_req_t);

endpackage

// File: rtl/ar_request_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of i_mask scanning from i_ptr upward, mod N.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        // Scan from the far end so the closest candidate to i_ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % N;
            if (i_mask[w_j]) begin
                o_any = 1'b1;
                o_idx = IW'(w_j);
            end
        end
        if (o_any) o_gnt[o_idx] = 1'b1;
    end

endmodule

// File: rtl/ar_request_arbiter.sv
// Round-robin AR arbiter with per-source outstanding-read credits and one registered output slot.
// Build option: define ARB_QOS_PRIO_EN to restrict arbitration to the highest-qos eligible sources.
module ar_request_arbiter
    import ar_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = AR_ID_W,
    parameter int ADDR_WIDTH  = AR_ADDR_W,
    parameter int LEN_WIDTH   = AR_LEN_W,
    parameter int SIZE_WIDTH  = AR_SIZE_W,
    parameter int BURST_WIDTH = AR_BURST_W,
    parameter int QOS_WIDTH   = AR_QOS_W,
    parameter int MAX_OUTST   = 8,
    localparam int AR_W  = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_WIDTH + QOS_WIDTH,
    localparam int SRC_W = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*AR_W-1:0] req_ar,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AR_W-1:0]         out_ar,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    buf_full,
    input  logic                    done_valid,
    input  logic [SRC_W-1:0]        done_src,
    output logic                    credit_err
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    logic                          r_out_valid;
    logic [AR_W-1:0]               r_out_ar;
    logic [SRC_W-1:0]              r_out_src;
    logic [SRC_W-1:0]              r_rr_ptr;
    logic                          r_credit_err;
    logic [NUM_REQ-1:0][CW-1:0]    r_cnt;

    logic [NUM_REQ-1:0][CW-1:0]    w_cnt_nxt;
    logic [NUM_REQ-1:0][AR_W-1:0]  w_ar;
    logic [NUM_REQ-1:0]            w_elig;
    logic [NUM_REQ-1:0]            w_cand;
    logic [NUM_REQ-1:0]            w_gnt;
    logic [SRC_W-1:0]              w_idx;
    logic                          w_any;
    logic                          w_slot_free;
    logic                          w_grant;
    logic                          w_err_ev;
    logic                          w_range_err;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign w_ar[i]   = req_ar[i*AR_W +: AR_W];
        assign w_elig[i] = req_valid[i] & (r_cnt[i] != CW'(MAX_OUTST));
    end

`ifdef ARB_QOS_PRIO_EN
    logic [QOS_WIDTH-1:0] w_qos_max;

    // qos sits in the LSBs of each packed request.
    always_comb begin
        w_qos_max = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_elig[i] && (w_ar[i][QOS_WIDTH-1:0] > w_qos_max))
                w_qos_max = w_ar[i][QOS_WIDTH-1:0];
        end
        w_cand = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_cand[i] = w_elig[i] & (w_ar[i][QOS_WIDTH-1:0] == w_qos_max);
    end
`else
    assign w_cand = w_elig;
`endif

    rr_picker #(.N(NUM_REQ), .IW(SRC_W)) u_pick (
        .i_mask (w_cand),
        .i_ptr  (r_rr_ptr),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_grant     = w_slot_free & ~buf_full & w_any;
    assign req_ready   = w_grant ? w_gnt : '0;

    assign w_range_err = done_valid & (int'(done_src) >= NUM_REQ);

    // A done against an empty counter is dropped; any same-cycle grant still counts.
    always_comb begin
        logic inc, dec, under;
        w_err_ev = w_range_err;
        inc      = 1'b0;
        dec      = 1'b0;
        under    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            inc   = w_grant & (w_idx == SRC_W'(i));
            dec   = done_valid & (done_src == SRC_W'(i));
            under = dec & (r_cnt[i] == '0);
            w_err_ev = w_err_ev | under;
            w_cnt_nxt[i] = r_cnt[i];
            if (inc && !(dec && !under))
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            else if (!inc && dec && !under)
                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_ar     <= '0;
            r_out_src    <= '0;
            r_rr_ptr     <= '0;
            r_credit_err <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_err_ev) r_credit_err <= 1'b1;
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_ar    <= w_ar[w_idx];
                r_out_src   <= w_idx;
                r_rr_ptr    <= (w_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ar     = r_out_ar;
    assign out_src    = r_out_src;
    assign credit_err = r_credit_err;

endmodule

// File: tb/tb_ar_request_arbiter.sv
// Directed bench for ar_request_arbiter (NUM_REQ=4, MAX_OUTST=2) with immediate-assertion checks.
module tb_ar_request_arbiter;
    import ar_pkg::*;

    localparam int N     = 4;
    localparam int AR_W  = AR_W_DEF;
    localparam int SRC_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*AR_W-1:0] req_ar;
    logic             out_valid;
    logic             out_ready;
    logic [AR_W-1:0]  out_ar;
    logic [SRC_W-1:0] out_src;
    logic             buf_full;
    logic             done_valid;
    logic [SRC_W-1:0] done_src;
    logic             credit_err;

    int total = 0;
    int bad   = 0;

    ar_request_arbiter #(.NUM_REQ(N), .MAX_OUTST(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ar     (req_ar),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ar     (out_ar),
        .out_src    (out_src),
        .buf_full   (buf_full),
        .done_valid (done_valid),
        .done_src   (done_src),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    function automatic ar_req_t mk(input int i, input int q);
        ar_req_t r;
        r.id    = AR_ID_W'(i);
        r.addr  = 32'h1000_0000 + 32'(i) * 32'h10;
        r.len   = AR_LEN_W'(i + 1);
        r.size  = 3'd2;
        r.burst = 2'b01;
        r.qos   = AR_QOS_W'(q);
        return r;
    endfunction

    task automatic set_ar(input int i, input int q);
        ar_req_t r;
        r = mk(i, q);
        req_ar[i*AR_W +: AR_W] = r;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic done_pulse(input int s);
        done_valid = 1'b1;
        done_src   = SRC_W'(s);
        tick();
        done_valid = 1'b0;
    endtask

    initial begin
        ar_req_t e;
        rst_n = 1'b1; req_valid = '0; req_ar = '0; out_ready = 1'b0;
        buf_full = 1'b0; done_valid = 1'b0; done_src = '0;
        for (int i = 0; i < N; i++) set_ar(i, 0);

        // async reset, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_credit_err", credit_err, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_ar", out_ar, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // round robin 0,1,2,3,0
        out_ready = 1'b1; req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", req_ready, 64'(1 << (k % 4)));
            tick();
            chk("rr_src", out_src, 64'(k % 4));
            chk("rr_valid", out_valid, 1);
        end
        e = mk(0, 0);
        chk("rr_ar", out_ar, e);
        req_valid = '0;
        tick();
        chk("rr_drain", out_valid, 0);
        done_pulse(0); done_pulse(0); done_pulse(1); done_pulse(2); done_pulse(3);
        chk("rr_err", credit_err, 0);

        // stall with out_ready low, rr_ptr=1
        req_valid = 4'b0100;
        #1 chk("st_first", req_ready, 4'b0100);
        tick();
        chk("st_src", out_src, 2);
        out_ready = 1'b0; req_valid = 4'hF;
        e = mk(2, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("st_ready", req_ready, 0);
            chk("st_hold_src", out_src, 2);
            chk("st_hold_ar", out_ar, e);
            chk("st_hold_vld", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("st_release", req_ready, 4'b1000);
        tick();
        chk("st_next_src", out_src, 3);
        req_valid = '0;
        tick();
        chk("st_drain", out_valid, 0);
        done_pulse(2); done_pulse(3);

        // credit limit on src1, rr_ptr=0
        req_valid = 4'b0010;
        #1 chk("cr_g1", req_ready, 4'b0010);
        tick();
        chk("cr_g2", req_ready, 4'b0010);
        tick();
        chk("cr_full", req_ready, 0);
        tick();
        chk("cr_idle", out_valid, 0);
        done_valid = 1'b1; done_src = 2'd1;
        #1 chk("cr_done_cycle", req_ready, 0);
        tick();
        done_valid = 1'b0;
        #1 chk("cr_regrant", req_ready, 4'b0010);
        tick();
        chk("cr_src", out_src, 1);
        chk("cr_full2", req_ready, 0);
        req_valid = '0;
        done_pulse(1); done_pulse(1);

        // same-cycle grant+done on src2, rr_ptr=2
        req_valid = 4'b0100;
        #1 chk("sc_g1", req_ready, 4'b0100);
        tick();
        done_valid = 1'b1; done_src = 2'd2;
        #1 chk("sc_g2", req_ready, 4'b0100);
        tick();
        done_valid = 1'b0;
        #1 chk("sc_g3", req_ready, 4'b0100);
        tick();
        chk("sc_block", req_ready, 0);
        req_valid = '0;
        done_pulse(2); done_pulse(2);
        chk("sc_err", credit_err, 0);

        // buf_full suppresses grants
        req_valid = 4'b0001; buf_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bf_ready", req_ready, 0);
            tick();
            chk("bf_valid", out_valid, 0);
        end
        buf_full = 1'b0;
        #1 chk("bf_release", req_ready, 4'b0001);
        tick();
        chk("bf_src", out_src, 0);
        req_valid = '0;
        done_pulse(0);

        // done on empty src3 -> sticky credit_err
        done_valid = 1'b1; done_src = 2'd3;
        #1 chk("ce_before", credit_err, 0);
        tick();
        done_valid = 1'b0;
        chk("ce_set", credit_err, 1);
        tick(); tick();
        chk("ce_sticky", credit_err, 1);

        // move rr_ptr to 0, then qos contest src0(qos1) vs src2(qos7)
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        done_pulse(3);
        set_ar(0, 1); set_ar(2, 7);
        req_valid = 4'b0101;
`ifdef ARB_QOS_PRIO_EN
        #1 chk("qos_ready", req_ready, 4'b0100);
        tick();
        chk("qos_src", out_src, 2);
        e = mk(2, 7);
`else
        #1 chk("qos_ready", req_ready, 4'b0001);
        tick();
        chk("qos_src", out_src, 0);
        e = mk(0, 1);
`endif
        chk("qos_ar", out_ar, e);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
